// File: rtl/taxi_eth_mac_swap.sv
// Byte-wide AXI-stream stage for the MAC loopback path.
// Swaps the destination and source MAC address fields of each frame so that
// a looped-back frame returns to its sender. The rest of the frame passes
// through unchanged. Frames too short to hold both addresses are emitted
// unmodified, flagged bad, and counted. A per-frame bypass is taken from
// cfg_enable on the first byte of each frame.
module taxi_eth_mac_swap #(
  parameter int HDR_LEN = 12,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       s_axis_tdata,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  input  logic             s_axis_tlast,
  input  logic             s_axis_tuser,
  output logic [7:0]       m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             m_axis_tlast,
  output logic             m_axis_tuser,
  input  logic             cfg_enable,
  output logic             stat_runt,
  output logic [CNT_W-1:0] runt_count
);

  localparam int HALF = HDR_LEN / 2;
  localparam int IW   = $clog2(HDR_LEN);
  localparam logic [IW-1:0] LAST_IDX = IW'(HDR_LEN - 1);
  localparam logic [IW-1:0] HALF_IDX = IW'(HALF);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR_IN,
    S_HDR_OUT,
    S_PASS,
    S_RUNT_OUT
  } state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    cnt_q, cnt_d;          // header bytes received
  logic [IW-1:0]    out_cnt_q, out_cnt_d;  // buffered bytes emitted
  logic [IW-1:0]    runt_len_q, runt_len_d;// index of the last runt byte
  logic             hdr_last_q, hdr_last_d;// frame ended exactly at header end
  logic             user_q, user_d;        // tuser latched on that tlast

  logic [7:0]       m_data_q, m_data_d;
  logic             m_valid_q, m_valid_d;
  logic             m_last_q, m_last_d;
  logic             m_user_q, m_user_d;
  logic             stat_runt_q, stat_runt_d;
  logic [CNT_W-1:0] runt_count_q;

  logic [7:0]       hdr_buf [HDR_LEN];
  logic             buf_we;
  logic [IW-1:0]    buf_waddr;

  logic             load_ok;
  logic             s_ready;
  logic             s_fire;
  logic             out_load;
  logic [IW-1:0]    hdr_idx;

  // The output register may take a new byte when empty or being drained.
  assign load_ok = !m_valid_q || m_axis_tready;
  assign s_fire  = s_axis_tvalid && s_ready;

  // Output byte k of the header comes from buffer slot (k + HALF) mod HDR_LEN.
  assign hdr_idx = (out_cnt_q < HALF_IDX) ? (out_cnt_q + HALF_IDX)
                                          : (out_cnt_q - HALF_IDX);

  // Next-state, buffer write and output-register load decisions.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_cnt_d   = out_cnt_q;
    runt_len_d  = runt_len_q;
    hdr_last_d  = hdr_last_q;
    user_d      = user_q;
    s_ready     = 1'b0;
    buf_we      = 1'b0;
    buf_waddr   = cnt_q;
    out_load    = 1'b0;
    m_data_d    = m_data_q;
    m_last_d    = m_last_q;
    m_user_d    = m_user_q;
    stat_runt_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Swap mode only buffers the first byte; bypass must forward it.
        s_ready = cfg_enable || load_ok;
        if (s_fire) begin
          if (cfg_enable) begin
            buf_we    = 1'b1;
            buf_waddr = '0;
            if (s_axis_tlast) begin
              runt_len_d = '0;
              out_cnt_d  = '0;
              state_d    = S_RUNT_OUT;
            end else begin
              cnt_d   = IW'(1);
              state_d = S_HDR_IN;
            end
          end else begin
            out_load = 1'b1;
            m_data_d = s_axis_tdata;
            m_last_d = s_axis_tlast;
            m_user_d = s_axis_tlast && s_axis_tuser;
            if (!s_axis_tlast) begin
              state_d = S_PASS;
            end
          end
        end
      end

      S_HDR_IN: begin
        s_ready = 1'b1;
        if (s_fire) begin
          buf_we    = 1'b1;
          buf_waddr = cnt_q;
          if (cnt_q == LAST_IDX) begin
            hdr_last_d = s_axis_tlast;
            user_d     = s_axis_tlast && s_axis_tuser;
            cnt_d      = '0;
            state_d    = S_HDR_OUT;
            // Slot HALF was written earlier, so the first swapped byte can
            // be loaded in the same cycle the header completes.
            if (load_ok) begin
              out_load  = 1'b1;
              m_data_d  = hdr_buf[HALF];
              m_last_d  = 1'b0;
              m_user_d  = 1'b0;
              out_cnt_d = IW'(1);
            end else begin
              out_cnt_d = '0;
            end
          end else if (s_axis_tlast) begin
            runt_len_d = cnt_q;
            out_cnt_d  = '0;
            cnt_d      = '0;
            state_d    = S_RUNT_OUT;
          end else begin
            cnt_d = cnt_q + IW'(1);
          end
        end
      end

      S_HDR_OUT: begin
        if (load_ok) begin
          out_load = 1'b1;
          m_data_d = hdr_buf[hdr_idx];
          if (out_cnt_q == LAST_IDX) begin
            m_last_d  = hdr_last_q;
            m_user_d  = hdr_last_q && user_q;
            out_cnt_d = '0;
            state_d   = hdr_last_q ? S_IDLE : S_PASS;
          end else begin
            m_last_d  = 1'b0;
            m_user_d  = 1'b0;
            out_cnt_d = out_cnt_q + IW'(1);
          end
        end
      end

      S_PASS: begin
        s_ready = load_ok;
        if (s_fire) begin
          out_load = 1'b1;
          m_data_d = s_axis_tdata;
          m_last_d = s_axis_tlast;
          m_user_d = s_axis_tlast && s_axis_tuser;
          if (s_axis_tlast) begin
            state_d = S_IDLE;
          end
        end
      end

      S_RUNT_OUT: begin
        // Runts leave in received order; the final byte is forced bad.
        if (load_ok) begin
          out_load = 1'b1;
          m_data_d = hdr_buf[out_cnt_q];
          if (out_cnt_q == runt_len_q) begin
            m_last_d    = 1'b1;
            m_user_d    = 1'b1;
            stat_runt_d = 1'b1;
            out_cnt_d   = '0;
            state_d     = S_IDLE;
          end else begin
            m_last_d  = 1'b0;
            m_user_d  = 1'b0;
            out_cnt_d = out_cnt_q + IW'(1);
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output valid sets on load and clears once the byte is taken.
  always_comb begin
    m_valid_d = m_valid_q;
    if (out_load) begin
      m_valid_d = 1'b1;
    end else if (m_axis_tready) begin
      m_valid_d = 1'b0;
    end
  end

  // Control state, output register and statistics.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      out_cnt_q    <= '0;
      runt_len_q   <= '0;
      hdr_last_q   <= 1'b0;
      user_q       <= 1'b0;
      m_data_q     <= '0;
      m_valid_q    <= 1'b0;
      m_last_q     <= 1'b0;
      m_user_q     <= 1'b0;
      stat_runt_q  <= 1'b0;
      runt_count_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_cnt_q   <= out_cnt_d;
      runt_len_q  <= runt_len_d;
      hdr_last_q  <= hdr_last_d;
      user_q      <= user_d;
      m_data_q    <= m_data_d;
      m_valid_q   <= m_valid_d;
      m_last_q    <= m_last_d;
      m_user_q    <= m_user_d;
      stat_runt_q <= stat_runt_d;
      if (stat_runt_d && (runt_count_q != {CNT_W{1'b1}})) begin
        runt_count_q <= runt_count_q + CNT_W'(1);
      end
    end
  end

  // Header buffer; contents are only read after being written in a frame.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      hdr_buf[buf_waddr] <= s_axis_tdata;
    end
  end

  assign s_axis_tready = s_ready && !rst;
  assign m_axis_tdata  = m_data_q;
  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tlast  = m_last_q;
  assign m_axis_tuser  = m_user_q;
  assign stat_runt     = stat_runt_q;
  assign runt_count    = runt_count_q;

endmodule

// File: tb/tb_taxi_eth_mac_swap.sv
// Scoreboard bench for taxi_eth_mac_swap: expected bytes are queued when a
// frame is driven and compared as the sink accepts output bytes.
module tb_taxi_eth_mac_swap;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tlast;
  logic        s_axis_tuser;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic        m_axis_tuser;
  logic        cfg_enable;
  logic        stat_runt;
  logic [15:0] runt_count;

  taxi_eth_mac_swap #(.HDR_LEN(12), .CNT_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tlast (s_axis_tlast),
    .s_axis_tuser (s_axis_tuser),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tuser (m_axis_tuser),
    .cfg_enable   (cfg_enable),
    .stat_runt    (stat_runt),
    .runt_count   (runt_count)
  );

  always #4 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  logic [9:0]  exp_q [$];          // {last, user, data}
  logic [7:0]  fr [1500];
  int          runt_exp  = 0;
  int          runt_seen = 0;
  int          acc_cyc   = 0;
  int          first_cyc = 0;
  int          out_idx   = 0;
  int          bytes_acc = 0;
  bit          abort     = 0;
  bit          rnd_ready = 0;
  bit          prev_stall = 0;
  logic [10:0] prev_out;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Sink ready: always ready, or a 50% coin toss each cycle.
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_axis_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output monitor: stall stability, scoreboard pop, runt pulse tracking.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 0;
      out_idx    = 0;
    end else begin
      if (prev_stall)
        check_val("hold", {21'd0, m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata},
                  {21'd0, 1'b1, prev_out[9:0]});
      if (stat_runt) begin
        runt_seen++;
        check_val("runt_pulse_on_last", {31'd0, m_axis_tvalid && m_axis_tlast}, 32'd1);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          check_val("extra_byte", {24'd0, m_axis_tdata}, 32'hFFFF_FFFF);
        end else begin
          logic [9:0] e;
          e = exp_q.pop_front();
          check_val($sformatf("byte%0d", out_idx),
                    {22'd0, m_axis_tlast, m_axis_tuser, m_axis_tdata}, {22'd0, e});
        end
        if (out_idx == 0) first_cyc = cyc;
        out_idx = m_axis_tlast ? 0 : out_idx + 1;
        $display("out byte data=%02h last=%0d user=%0d", m_axis_tdata, m_axis_tlast, m_axis_tuser);
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_out   = {m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata};
    end
  end

  // Queue the expected output for the frame in fr[0:len-1], then drive it.
  task automatic send_frame(input int len, input logic en, input logic usr, input bit rnd);
    int trig;
    for (int i = 0; i < len; i++) begin
      int idx;
      logic last, user;
      idx  = (en && len >= 12 && i < 12) ? (i + 6) % 12 : i;
      last = (i == len - 1);
      user = last ? ((en && len < 12) ? 1'b1 : usr) : 1'b0;
      exp_q.push_back({last, user, fr[idx]});
    end
    if (en && len < 12) runt_exp++;
    trig = (en && len >= 12) ? 11 : 0;
    for (int i = 0; i < len; i++) begin
      int tmo;
      if (rnd && $urandom_range(0, 2) == 0) begin
        s_axis_tvalid = 1'b0;
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = fr[i];
      s_axis_tlast  = (i == len - 1);
      s_axis_tuser  = (i == len - 1) ? usr : (rnd ? 1'($urandom_range(0, 1)) : 1'b0);
      cfg_enable    = (i == 0) ? en : (rnd ? 1'($urandom_range(0, 1)) : en);
      tmo = 0;
      forever begin
        @(negedge clk);
        if (abort) begin
          s_axis_tvalid = 1'b0;
          return;
        end
        if (s_axis_tready) begin
          if (i == trig) acc_cyc = cyc;
          bytes_acc++;
          @(posedge clk);
          #1;
          break;
        end
        tmo++;
        if (tmo > 5000) begin
          check_val("in_timeout", 32'd1, 32'd0);
          s_axis_tvalid = 1'b0;
          return;
        end
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    $display("sent frame len=%0d en=%0d tuser=%0d", len, en, usr);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 20000) begin
      @(posedge clk);
      n++;
    end
    check_val("drain", exp_q.size(), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic make_std_frame();
    fr[0] = 8'h02; fr[1] = 8'h00; fr[2] = 8'h00; fr[3] = 8'h00; fr[4] = 8'h00; fr[5] = 8'h01;
    fr[6] = 8'h02; fr[7] = 8'h00; fr[8] = 8'h00; fr[9] = 8'h00; fr[10] = 8'h00; fr[11] = 8'h02;
    for (int i = 12; i < 64; i++) fr[i] = 8'(i);
  endtask

  initial begin
    rst = 1'b1;
    s_axis_tvalid = 1'b0; s_axis_tdata = 8'h00; s_axis_tlast = 1'b0;
    s_axis_tuser = 1'b0;  cfg_enable = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_tready",  {31'd0, s_axis_tready}, 32'd0);
    check_val("rst_tvalid",  {31'd0, m_axis_tvalid}, 32'd0);
    check_val("rst_tdata",   {24'd0, m_axis_tdata}, 32'd0);
    check_val("rst_runtcnt", {16'd0, runt_count}, 32'd0);
    check_val("rst_stat",    {31'd0, stat_runt}, 32'd0);
    rst = 1'b0;
    #1;
    check_val("idle_tready", {31'd0, s_axis_tready}, 32'd1);
    @(posedge clk); #1;

    // 64-byte frame, swap enabled
    make_std_frame();
    send_frame(64, 1'b1, 1'b0, 0);
    wait_drain();
    check_val("lat_swap", first_cyc - acc_cyc, 32'd1);

    // Same frame, bypass
    send_frame(64, 1'b0, 1'b0, 0);
    wait_drain();
    check_val("lat_bypass", first_cyc - acc_cyc, 32'd1);

    // 5-byte runt
    for (int i = 0; i < 5; i++) fr[i] = 8'hA0 + 8'(i);
    runt_seen = 0;
    send_frame(5, 1'b1, 1'b0, 0);
    wait_drain();
    check_val("runt5_pulses", runt_seen, 32'd1);
    check_val("runt5_count",  {16'd0, runt_count}, 32'd1);

    // Exactly 12 bytes, input tuser set on tlast
    for (int i = 0; i < 12; i++) fr[i] = 8'h10 + 8'(i);
    send_frame(12, 1'b1, 1'b1, 0);
    wait_drain();
    check_val("hdr12_runtcnt", {16'd0, runt_count}, 32'd1);

    // Random traffic with gaps, backpressure and mid-frame cfg changes
    rnd_ready = 1;
    runt_seen = 0;
    runt_exp  = 1;
    for (int f = 0; f < 200; f++) begin
      int len, sel;
      logic en;
      sel = $urandom_range(0, 99);
      if (sel < 25)      len = $urandom_range(1, 11);
      else if (sel < 95) len = $urandom_range(12, 64);
      else               len = $urandom_range(65, 1500);
      if (f == 0) len = 1500;
      if (f == 1) len = 1;
      en = ($urandom_range(0, 4) != 0);
      for (int i = 0; i < len; i++) fr[i] = 8'($urandom);
      send_frame(len, en, 1'($urandom_range(0, 1)), 1);
    end
    wait_drain();
    check_val("rnd_runtcnt", {16'd0, runt_count}, runt_exp);
    check_val("rnd_pulses",  runt_seen, runt_exp - 1);
    rnd_ready = 0;
    repeat (2) @(posedge clk); #1;

    // Reset in the middle of a 100-byte frame's pass-through section
    for (int i = 0; i < 100; i++) fr[i] = 8'($urandom);
    bytes_acc = 0;
    fork
      send_frame(100, 1'b1, 1'b0, 0);
      begin
        int n = 0;
        while (bytes_acc < 40 && n < 2000) begin
          @(negedge clk);
          n++;
        end
        check_val("rst_reach40", {31'd0, bytes_acc >= 40}, 32'd1);
        #2;
        rst   = 1'b1;
        abort = 1'b1;
        #1;
        check_val("midrst_tvalid",  {31'd0, m_axis_tvalid}, 32'd0);
        check_val("midrst_runtcnt", {16'd0, runt_count}, 32'd0);
        check_val("midrst_tready",  {31'd0, s_axis_tready}, 32'd0);
      end
    join
    exp_q.delete();
    runt_exp = 0;
    repeat (2) @(posedge clk);
    #1;
    abort = 1'b0;
    rst   = 1'b0;
    @(posedge clk); #1;

    // Frame after reset must be swapped correctly
    make_std_frame();
    send_frame(20, 1'b1, 1'b0, 0);
    wait_drain();
    check_val("post_rst_runtcnt", {16'd0, runt_count}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
